// File: rtl/rif_mailbox.sv
// CSR slave on the rif_* bus fronting a host->core TX mailbox FIFO and a core->host RX mailbox FIFO.
// Optional interrupt registers (IRQ_STAT/IRQ_MASK, irq) are built when RIF_MAILBOX_IRQ_EN is defined.

module rif_mailbox_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   lvl;
    logic          do_push, do_pop;

    assign empty   = (lvl == '0);
    assign full    = (lvl == (AW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rp];
    assign level   = lvl;

    // Full/empty are pre-edge, so a push into a full FIFO is refused even if a pop also happens.
    always_ff @(posedge HCLK) begin
        if (HRESET || flush) begin
            wp  <= '0;
            rp  <= '0;
            lvl <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            lvl <= lvl + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge HCLK) begin
        if (do_push) mem[wp] <= wdata;
    end
endmodule

module rif_mailbox #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BYTE_COUNT = DATA_WIDTH/8,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [ADDR_WIDTH-1:0] rif_addr,
    output logic                  rif_addr_valid,
    input  logic                  rif_wr_req,
    input  logic                  rif_rd_req,
    input  logic [BYTE_COUNT-1:0] rif_wstrb,
    input  logic [DATA_WIDTH-1:0] rif_wdata,
    output logic [DATA_WIDTH-1:0] rif_rdata,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  irq
);
    localparam int LSB = $clog2(BYTE_COUNT);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic ctrl;
        logic txdata;
        logic cmd;
        logic irq_stat;
        logic irq_mask;
        logic scratch;
    } wr_dec_t;

    logic [2:0]            k;
    logic                  in_win, reg_ok;
    wr_dec_t               we;
    logic [1:0]            ctrl;
    logic [DATA_WIDTH-1:0] scratch;
    logic [2:0]            irq_stat, irq_mask;

    logic                  tx_push, tx_pop, tx_flush, tx_empty, tx_full;
    logic                  rx_push, rx_pop, rx_flush, rx_empty, rx_full;
    logic [DATA_WIDTH-1:0] rx_head;
    logic [LW-1:0]         tx_lvl, rx_lvl;
    logic                  tx_ovf_ev, rx_unf_ev;
    logic                  unused_ok;

    // BASE_ADDR is aligned to the 8-register window, so the upper bits alone select it.
    assign k      = rif_addr[LSB+2:LSB];
    assign in_win = (rif_addr[ADDR_WIDTH-1:LSB+3] == BASE_ADDR[ADDR_WIDTH-1:LSB+3]);

    always_comb begin
        reg_ok = 1'b1;
`ifndef RIF_MAILBOX_IRQ_EN
        if (k == 3'd5 || k == 3'd6) reg_ok = 1'b0;
`endif
    end

    assign rif_addr_valid = in_win & reg_ok;

    always_comb begin
        we          = '0;
        we.ctrl     = rif_wr_req & rif_addr_valid & (k == 3'd0);
        we.txdata   = rif_wr_req & rif_addr_valid & (k == 3'd2);
        we.cmd      = rif_wr_req & rif_addr_valid & (k == 3'd4);
        we.irq_stat = rif_wr_req & rif_addr_valid & (k == 3'd5);
        we.irq_mask = rif_wr_req & rif_addr_valid & (k == 3'd6);
        we.scratch  = rif_wr_req & rif_addr_valid & (k == 3'd7);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET)                       ctrl <= '0;
        else if (we.ctrl && rif_wstrb[0]) ctrl <= rif_wdata[1:0];
    end

    for (genvar b = 0; b < BYTE_COUNT; b++) begin : g_scratch
        always_ff @(posedge HCLK) begin
            if (HRESET)                        scratch[b*8 +: 8] <= '0;
            else if (we.scratch && rif_wstrb[b]) scratch[b*8 +: 8] <= rif_wdata[b*8 +: 8];
        end
    end

    assign tx_push  = we.txdata & (|rif_wstrb);
    assign tx_pop   = tx_valid & tx_ready;
    assign tx_flush = we.cmd & rif_wdata[1];
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = we.cmd & rif_wdata[0];
    assign rx_flush = we.cmd & rif_wdata[2];

    rif_mailbox_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx (
        .HCLK(HCLK), .HRESET(HRESET), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
        .wdata(rif_wdata), .head(tx_data), .empty(tx_empty), .full(tx_full), .level(tx_lvl)
    );

    rif_mailbox_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx (
        .HCLK(HCLK), .HRESET(HRESET), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
        .wdata(rx_data), .head(rx_head), .empty(rx_empty), .full(rx_full), .level(rx_lvl)
    );

    assign tx_valid = ctrl[0] & ~tx_empty;
    assign rx_ready = ctrl[1] & ~rx_full;

    // A flush in the same cycle suppresses the error it would otherwise mask.
    assign tx_ovf_ev = tx_push & tx_full & ~tx_flush;
    assign rx_unf_ev = rx_pop & rx_empty & ~rx_flush;

`ifdef RIF_MAILBOX_IRQ_EN
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            irq_stat <= '0;
            irq_mask <= '0;
        end else begin
            irq_stat <= (irq_stat & ~({3{we.irq_stat}} & rif_wdata[2:0]))
                      | {rx_unf_ev, tx_ovf_ev, rx_push};
            if (we.irq_mask) irq_mask <= rif_wdata[2:0];
        end
    end
    assign irq = |(irq_stat & irq_mask);
`else
    assign irq_stat = '0;
    assign irq_mask = '0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        rif_rdata = '0;
        if (rif_addr_valid) begin
            case (k)
                3'd0: rif_rdata[1:0]  = ctrl;
                3'd1: rif_rdata[23:0] = {8'(rx_lvl), 8'(tx_lvl), 4'b0,
                                         rx_full, rx_empty, tx_full, tx_empty};
                3'd3: if (!rx_empty) rif_rdata = rx_head;
                3'd5: rif_rdata[2:0]  = irq_stat;
                3'd6: rif_rdata[2:0]  = irq_mask;
                3'd7: rif_rdata       = scratch;
                default: rif_rdata    = '0;
            endcase
        end
    end

    // Reads are side-effect free, so the read strobe and sub-word address bits are not needed.
    assign unused_ok = ^{rif_rd_req, rif_addr[LSB-1:0], tx_ovf_ev, rx_unf_ev,
                         we.irq_stat, we.irq_mask};
endmodule

// File: tb/tb_rif_mailbox.sv
// Self-checking bench for rif_mailbox: directed test-plan steps then random traffic,
// all outputs compared every cycle against a queue-based behavioural model.
module tb_rif_mailbox;
    localparam int D = 4;
`ifdef RIF_MAILBOX_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [11:0] rif_addr;
    logic        rif_addr_valid;
    logic        rif_wr_req, rif_rd_req;
    logic [3:0]  rif_wstrb;
    logic [31:0] rif_wdata, rif_rdata;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;
    logic [31:0] tx_data, rx_data;

    rif_mailbox dut (
        .HCLK(HCLK), .HRESET(HRESET), .rif_addr(rif_addr), .rif_addr_valid(rif_addr_valid),
        .rif_wr_req(rif_wr_req), .rif_rd_req(rif_rd_req), .rif_wstrb(rif_wstrb),
        .rif_wdata(rif_wdata), .rif_rdata(rif_rdata), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .irq(irq)
    );

    always #5 HCLK = ~HCLK;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mq_tx[$];
    logic [31:0] mq_rx[$];
    logic [1:0]  m_ctrl;
    logic [2:0]  m_stat, m_mask;
    logic [31:0] m_scr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        mq_tx.delete();
        mq_rx.delete();
        m_ctrl = '0; m_stat = '0; m_mask = '0; m_scr = '0;
    endtask

    function automatic bit m_valid(input logic [11:0] a);
        int k = int'(a >> 2);
        return (k <= 7) && (IRQ || (k != 5 && k != 6));
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        int k = int'(a >> 2);
        int nt = mq_tx.size();
        int nr = mq_rx.size();
        if (!m_valid(a)) return 32'h0;
        case (k)
            0: return {30'h0, m_ctrl};
            1: return (32'(nr) << 16) | (32'(nt) << 8) | (32'(nr == D) << 3) |
                      (32'(nr == 0) << 2) | (32'(nt == D) << 1) | 32'(nt == 0);
            3: return (nr > 0) ? mq_rx[0] : 32'h0;
            5: return {29'h0, m_stat};
            6: return {29'h0, m_mask};
            7: return m_scr;
            default: return 32'h0;
        endcase
    endfunction

    // Check all outputs against the model just before the edge, then advance the model.
    task automatic tick();
        bit m_txv, m_rxr, wv, tfl, rfl, tpreq, rpreq, ovf, unf, rpush;
        int k;
        @(negedge HCLK);
        m_txv = m_ctrl[0] && mq_tx.size() > 0;
        m_rxr = m_ctrl[1] && mq_rx.size() < D;
        chk("addr_valid", 32'(rif_addr_valid), 32'(m_valid(rif_addr)));
        chk("rdata", rif_rdata, m_read(rif_addr));
        chk("tx_valid", 32'(tx_valid), 32'(m_txv));
        if (m_txv) chk("tx_data", tx_data, mq_tx[0]);
        chk("rx_ready", 32'(rx_ready), 32'(m_rxr));
        chk("irq", 32'(irq), 32'(IRQ && |(m_stat & m_mask)));
        if (HRESET) begin
            m_reset();
        end else begin
            k     = int'(rif_addr >> 2);
            wv    = rif_wr_req && m_valid(rif_addr);
            tfl   = wv && k == 4 && rif_wdata[1];
            rfl   = wv && k == 4 && rif_wdata[2];
            tpreq = wv && k == 2 && rif_wstrb != 0;
            rpreq = wv && k == 4 && rif_wdata[0];
            rpush = rx_valid && m_rxr;
            ovf   = tpreq && mq_tx.size() == D && !tfl;
            unf   = rpreq && mq_rx.size() == 0 && !rfl;
            if (tfl) mq_tx.delete();
            else begin
                if (m_txv && tx_ready) void'(mq_tx.pop_front());
                if (tpreq && mq_tx.size() + ((m_txv && tx_ready) ? 1 : 0) < D) mq_tx.push_back(rif_wdata);
            end
            if (rfl) mq_rx.delete();
            else begin
                if (rpreq && mq_rx.size() > 0) void'(mq_rx.pop_front());
                if (rpush) mq_rx.push_back(rx_data);
            end
            if (IRQ) begin
                m_stat = (m_stat & ~((wv && k == 5) ? rif_wdata[2:0] : 3'b0)) | {unf, ovf, rpush};
                if (wv && k == 6) m_mask = rif_wdata[2:0];
            end
            if (wv && k == 0 && rif_wstrb[0]) m_ctrl = rif_wdata[1:0];
            if (wv && k == 7)
                for (int b = 0; b < 4; b++)
                    if (rif_wstrb[b]) m_scr[b*8 +: 8] = rif_wdata[b*8 +: 8];
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input bit wr, input int k, input logic [3:0] s, input logic [31:0] d);
        rif_wr_req = wr;
        rif_rd_req = !wr;
        rif_addr   = 12'(k * 4);
        rif_wstrb  = s;
        rif_wdata  = d;
    endtask

    task automatic idle(input int k);
        drive(1'b0, k, 4'h0, 32'h0);
    endtask

    task automatic peek(input string tag, input logic [31:0] mask, input logic [31:0] exp);
        #1;
        chk(tag, rif_rdata & mask, exp);
    endtask

    initial begin
        HRESET = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        idle(0);
        @(posedge HCLK); #1;
        m_reset();
        tick();
        HRESET = 1'b0;

        // Reset state of every register, plus the first invalid index.
        for (int k = 0; k <= 8; k++) begin
            idle(k);
            peek("reset_read", 32'hFFFF_FFFF, (k == 1) ? 32'h5 : 32'h0);
            tick();
        end

        // TX fill to full, overflow, then drain.
        drive(1, 0, 4'hF, 32'h1); tick();
        for (int i = 0; i < 4; i++) begin drive(1, 2, 4'hF, 32'hA0 + i); tick(); end
        idle(1); peek("status_txfull", 32'h0000_FF03, 32'h0402); tick();
        drive(1, 2, 4'hF, 32'hA4); tick();
        idle(1); peek("status_after_ovf", 32'h0000_FF03, 32'h0402); tick();
        if (IRQ) begin idle(5); peek("tx_ovf", 32'h2, 32'h2); tick(); end
        tx_ready = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_valid", 32'(tx_valid), 32'h1);
            chk("drain_data", tx_data, 32'hA0 + i);
            tick();
        end
        #1; chk("drain_done", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // RX fill, non-popping reads, pops, underflow.
        drive(1, 0, 4'hF, 32'h2); tick();
        idle(3);
        rx_valid = 1'b1; rx_data = 32'h11; tick();
        rx_data = 32'h22; tick();
        rx_valid = 1'b0;
        peek("rxdata_head", 32'hFFFF_FFFF, 32'h11); tick();
        peek("rxdata_again", 32'hFFFF_FFFF, 32'h11); tick();
        drive(1, 4, 4'hF, 32'h1); tick();
        idle(3); peek("rxdata_pop", 32'hFFFF_FFFF, 32'h22); tick();
        drive(1, 4, 4'hF, 32'h1); tick();
        drive(1, 4, 4'hF, 32'h1); tick();
        idle(1); peek("rx_empty", 32'h4, 32'h4); tick();
        idle(3); peek("rxdata_empty", 32'hFFFF_FFFF, 32'h0); tick();
        if (IRQ) begin
            idle(5); peek("rx_unf", 32'h4, 32'h4); tick();
            // irq on RX push; set beats a same-cycle W1C.
            drive(1, 5, 4'hF, 32'h7); tick();
            drive(1, 6, 4'hF, 32'h1); tick();
            idle(0); rx_valid = 1'b1; rx_data = 32'h33; tick();
            rx_valid = 1'b0;
            #1; chk("irq_rise", 32'(irq), 32'h1);
            drive(1, 5, 4'hF, 32'h1); rx_valid = 1'b1; rx_data = 32'h44; tick();
            rx_valid = 1'b0;
            idle(5); peek("set_beats_clr", 32'h1, 32'h1);
            chk("irq_held", 32'(irq), 32'h1); tick();
            drive(1, 5, 4'hF, 32'h7); tick();
            idle(0); #1; chk("irq_fall", 32'(irq), 32'h0); tick();
        end

        // Flush beats a same-cycle handshake; no overflow raised.
        drive(1, 0, 4'hF, 32'h3); tick();
        for (int i = 0; i < 4; i++) begin drive(1, 2, 4'hF, 32'hB0 + i); tick(); end
        tx_ready = 1'b1;
        drive(1, 4, 4'hF, 32'h6); tick();
        tx_ready = 1'b0;
        idle(1); peek("flush_tx_lvl", 32'h0000_FF00, 32'h0);
        peek("flush_rx_lvl", 32'h00FF_0000, 32'h0); tick();
        if (IRQ) begin idle(5); peek("flush_no_ovf", 32'h2, 32'h0); tick(); end

        // SCRATCH byte strobes.
        drive(1, 7, 4'hF, 32'hFFFF_FFFF); tick();
        drive(1, 7, 4'h1, 32'h1234_5678); tick();
        idle(7); peek("scratch_strb", 32'hFFFF_FFFF, 32'hFFFF_FF78); tick();

        // Reset in the middle of traffic.
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_data = $urandom; drive(1, 2, 4'hF, $urandom); tick();
        end
        HRESET = 1'b1; tick();
        HRESET = 1'b0; rx_valid = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            idle(k);
            peek("post_reset", 32'hFFFF_FFFF, (k == 1) ? 32'h5 : 32'h0);
            tick();
        end

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            int k = $urandom_range(0, 9);
            rif_wr_req = $urandom_range(0, 1);
            rif_rd_req = $urandom_range(0, 1);
            rif_addr   = (($urandom_range(0, 15) == 0) ? 12'($urandom) : 12'(k * 4 + $urandom_range(0, 3)));
            rif_wstrb  = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            rif_wdata  = (k == 4) ? (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : 32'h1) : $urandom;
            if (k == 0) rif_wdata[1:0] = 2'($urandom_range(1, 3));
            tx_ready   = $urandom_range(0, 2) == 0;
            rx_valid   = $urandom_range(0, 1);
            rx_data    = $urandom;
            HRESET     = $urandom_range(0, 150) == 0;
            tick();
        end
        HRESET = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
